// File: rtl/dis_shuffle_ctrl.sv
// Keypad scramble controller: drives dis_clk_counter and Fisher-Yates shuffles
// the ten digits with a free-running Galois LFSR while the count runs.
module dis_shuffle_ctrl #(
    parameter logic [7:0] RESET_SEED = 8'h01,
    parameter int         COUNT_CAP  = 10,
    parameter int         TIMEOUT    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shuffle_req,
    input  logic        seed_load,
    input  logic [7:0]  seed,
    input  logic [3:0]  count_in,
    output logic        shuffle_init,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        key_map_valid,
    output logic [39:0] key_map,
    input  logic [3:0]  slot_sel,
    output logic [3:0]  slot_digit
);

    localparam int              TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      CAP4  = 4'(COUNT_CAP);
    localparam logic [TMR_W-1:0] TMO  = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [7:0]       lfsr;
    logic [3:0]       i_idx;
    logic [TMR_W-1:0] timer;
    logic [3:0]       j_idx;
    logic [39:0]      swap_map;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [39:0] identity_map();
        logic [39:0] m;
        for (int k = 0; k < 10; k++) m[4*k +: 4] = 4'(k);
        return m;
    endfunction

    // Scale the LFSR byte into 0..n-1 by keeping the top bits of an 8x4 product.
    function automatic logic [3:0] pick_j(input logic [7:0] v, input logic [3:0] n);
        logic [11:0] prod;
        prod = {4'd0, v} * {8'd0, n};
        return prod[11:8];
    endfunction

    always_comb begin
        j_idx    = pick_j(lfsr, i_idx + 4'd1);
        swap_map = key_map;
        swap_map[{i_idx, 2'b00} +: 4] = key_map[{j_idx, 2'b00} +: 4];
        swap_map[{j_idx, 2'b00} +: 4] = key_map[{i_idx, 2'b00} +: 4];
    end

    always_comb begin
        slot_digit = 4'hF;
        if (slot_sel <= 4'd9) slot_digit = key_map[{slot_sel, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shuffle_init  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            key_map_valid <= 1'b0;
            key_map       <= identity_map();
            lfsr          <= RESET_SEED;
            i_idx         <= 4'd0;
            timer         <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load) lfsr <= (seed == 8'h00) ? RESET_SEED : seed;
                    if (shuffle_req) begin
                        key_map       <= identity_map();
                        key_map_valid <= 1'b0;
                        i_idx         <= 4'd9;
                        timer         <= '0;
                        shuffle_init  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (i_idx == 4'd0 && count_in == CAP4) begin
                        shuffle_init  <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        key_map_valid <= 1'b1;
                        state         <= DONE;
                    end else if (timer == TMO) begin
                        // Counter never reached the cap: drop the partial shuffle.
                        shuffle_init  <= 1'b0;
                        busy          <= 1'b0;
                        err           <= 1'b1;
                        key_map       <= identity_map();
                        key_map_valid <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (i_idx != 4'd0) begin
                            key_map <= swap_map;
                            i_idx   <= i_idx - 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
